// File: rtl/as_rr_arbiter.sv
// Round-robin arbiter sharing one signed add/subtract datapath between requesters A and B.
// Latency: 1 cycle from accept edge to result in the registered output slot.
// Backpressure: while the slot is full and res_ready is low, both readys stay low and the slot holds.
module as_rr_arbiter #(
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_in_1,
    input  logic [WIDTH-1:0] a_in_2,
    input  logic             a_sel,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_in_1,
    input  logic [WIDTH-1:0] b_in_2,
    input  logic             b_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_data,
    output logic             res_id
);

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] in_2;
        logic [WIDTH-1:0] in_1;
    } op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t          slot_q;
    logic           last_grant_q;   // 0 = A, 1 = B
    op_t            a_op;
    op_t            b_op;
    op_t            win_op;
    logic           slot_free;
    logic           grant_a;
    logic           grant_b;
    logic           xfer;
    logic           win_id;
    logic [WIDTH:0] op1_ext;
    logic [WIDTH:0] op2_ext;
    logic [WIDTH:0] result;

    assign a_op = '{sel: a_sel, in_2: a_in_2, in_1: a_in_1};
    assign b_op = '{sel: b_sel, in_2: b_in_2, in_1: b_in_1};

    assign res_valid = (slot_q == FULL);
    assign slot_free = !res_valid || res_ready;

    // Contention goes to whoever was not served last; a lone requester always wins.
    assign grant_a = !rst && slot_free && a_valid && (!b_valid ||  last_grant_q);
    assign grant_b = !rst && slot_free && b_valid && (!a_valid || !last_grant_q);
    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign xfer   = grant_a || grant_b;
    assign win_id = grant_b;
    assign win_op = grant_b ? b_op : a_op;

    // One extra sign bit makes the sum/difference exact for any operand pair.
    assign op1_ext = {win_op.in_1[WIDTH-1], win_op.in_1};
    assign op2_ext = {win_op.in_2[WIDTH-1], win_op.in_2};
    assign result  = win_op.sel ? (op1_ext - op2_ext) : (op1_ext + op2_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= EMPTY;
            res_data     <= '0;
            res_id       <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (slot_q)
                EMPTY: begin
                    if (xfer) begin
                        slot_q       <= FULL;
                        res_data     <= result;
                        res_id       <= win_id;
                        last_grant_q <= win_id;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        res_data     <= result;
                        res_id       <= win_id;
                        last_grant_q <= win_id;
                    end else if (res_ready) begin
                        slot_q <= EMPTY;
                    end
                end
                default: slot_q <= EMPTY;
            endcase
        end
    end

endmodule
